// File: rtl/serial_accumulator_rounding_pkg.sv
// Shared numbers for the serial accumulator: state encoding and the
// accumulator-width / rounding-shift helpers used by the top and the rounder.
package serial_accumulator_rounding_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_ACC = 2'd0;
   localparam state_t ST_RND = 2'd1;
   localparam state_t ST_OUT = 2'd2;

   // Full-precision accumulator width: enough headroom for num_acc samples.
   function automatic int calc_acc_w(input int width_in, input int num_acc);
      return width_in + $clog2(num_acc);
   endfunction

   // Number of LSBs dropped (positive) or zero bits appended (negative).
   function automatic int calc_shift(input int acc_w, input int width_out);
      return acc_w - width_out;
   endfunction

endpackage

// File: rtl/serial_accumulator_rounding_round.sv
// Combinational ACC_W -> WIDTH_OUT rounder (round-half-to-even) and saturator.
// Macro SERIAL_ACC_SAT_FLAG_EN: when defined, sat_o reports saturation;
// otherwise sat_o is tied to 0 (the result is still saturated).
module round_half_even_sat
   import serial_accumulator_rounding_pkg::*;
#(
   parameter int ACC_W       = 10,
   parameter int WIDTH_OUT   = 8,
   parameter int IS_SIGNED   = 1,
   parameter int IS_FRACTION = 0
) (
   input  logic [ACC_W-1:0]     acc_i,
   output logic [WIDTH_OUT-1:0] data_o,
   output logic                 sat_o
);

   localparam int SHIFT = calc_shift(ACC_W, WIDTH_OUT);
   // Working width holds the accumulator, the output range and a rounding carry.
   localparam int EXT_W = ((ACC_W > WIDTH_OUT) ? ACC_W : WIDTH_OUT) + 2;
   localparam int RSH   = ((IS_FRACTION != 0) && (SHIFT > 0)) ? SHIFT : 0;
   localparam int LSH   = ((IS_FRACTION != 0) && (SHIFT < 0)) ? -SHIFT : 0;

   logic signed [EXT_W-1:0] one_s;
   logic signed [EXT_W-1:0] ext_s;
   logic signed [EXT_W-1:0] base_s;
   logic signed [EXT_W-1:0] rem_s;
   logic signed [EXT_W-1:0] half_s;
   logic signed [EXT_W-1:0] val_s;
   logic signed [EXT_W-1:0] max_s;
   logic signed [EXT_W-1:0] min_s;
   logic                    sign_bit;
   logic                    round_up;
   logic                    sat_hi;
   logic                    sat_lo;

   // Extend, drop/append bits with ties-to-even, then clamp to the output range.
   always_comb begin
      one_s    = EXT_W'(1);
      sign_bit = (IS_SIGNED != 0) ? acc_i[ACC_W-1] : 1'b0;
      ext_s    = {{(EXT_W-ACC_W){sign_bit}}, acc_i};
      base_s   = ext_s >>> RSH;
      rem_s    = ext_s & ((one_s <<< RSH) - one_s);
      half_s   = (one_s <<< RSH) >>> 1;
      // A tie only rounds up when the kept part is odd; no rounding without dropped bits.
      round_up = (RSH > 0) && ((rem_s > half_s) || ((rem_s == half_s) && base_s[0]));
      val_s    = (base_s + EXT_W'(round_up)) <<< LSH;
      max_s    = (IS_SIGNED != 0) ? ((one_s <<< (WIDTH_OUT-1)) - one_s)
                                  : ((one_s <<< WIDTH_OUT) - one_s);
      min_s    = (IS_SIGNED != 0) ? -(one_s <<< (WIDTH_OUT-1)) : '0;
      sat_hi   = (val_s > max_s);
      sat_lo   = (val_s < min_s);
      if (sat_hi) begin
         data_o = max_s[WIDTH_OUT-1:0];
      end else if (sat_lo) begin
         data_o = min_s[WIDTH_OUT-1:0];
      end else begin
         data_o = val_s[WIDTH_OUT-1:0];
      end
   end

`ifdef SERIAL_ACC_SAT_FLAG_EN
   assign sat_o = sat_hi | sat_lo;
`else
   assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/serial_accumulator_rounding.sv
// Serial accumulator: sums NUM_ACC accepted samples at full precision, rounds
// (half-to-even) and saturates to WIDTH_OUT, and presents it on a valid/ready port.
// Macro SERIAL_ACC_SAT_FLAG_EN: when defined, m_sat is registered with m_data;
// otherwise m_sat is constant 0.
module serial_accumulator_rounding
   import serial_accumulator_rounding_pkg::*;
#(
   parameter int NUM_ACC     = 4,
   parameter int WIDTH_IN    = 8,
   parameter int WIDTH_OUT   = 8,
   parameter int IS_SIGNED   = 1,
   parameter int IS_FRACTION = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 clear,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [WIDTH_IN-1:0]  s_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [WIDTH_OUT-1:0] m_data,
   output logic                 m_sat
);

   localparam int ACC_W = calc_acc_w(WIDTH_IN, NUM_ACC);
   localparam int CNT_W = $clog2(NUM_ACC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ACC - 1);

   if (WIDTH_IN <= 0) begin : g_chk_win
      $error("serial_accumulator_rounding: WIDTH_IN must be > 0");
   end
   if (WIDTH_OUT <= 0) begin : g_chk_wout
      $error("serial_accumulator_rounding: WIDTH_OUT must be > 0");
   end
   if (NUM_ACC < 2) begin : g_chk_nacc
      $error("serial_accumulator_rounding: NUM_ACC must be >= 2");
   end

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [WIDTH_OUT-1:0] data_q, data_d;
   logic                 alive_q, alive_d;

   logic                 last_cnt;
   logic                 accept;
   logic                 m_hs;
   logic                 ext_bit;
   logic [ACC_W-1:0]     sample_ext;
   logic [WIDTH_OUT-1:0] rnd_data;
   logic                 rnd_sat;

   assign last_cnt   = (cnt_q == CNT_LAST);
   assign ext_bit    = (IS_SIGNED != 0) ? s_data[WIDTH_IN-1] : 1'b0;
   assign sample_ext = {{(ACC_W-WIDTH_IN){ext_bit}}, s_data};
   assign m_valid    = ena && (state_q == ST_OUT);
   assign accept     = s_valid && s_ready;
   assign m_hs       = m_valid && m_ready;
   assign m_data     = data_q;

   // Ready: open in ACC; in OUT the batch-final sample waits for the result handshake.
   always_comb begin
      s_ready = 1'b0;
      if (ena && alive_q) begin
         case (state_q)
            ST_ACC:  s_ready = 1'b1;
            ST_OUT:  s_ready = !last_cnt || m_ready;
            default: s_ready = 1'b0;
         endcase
      end
   end

   round_half_even_sat #(
      .ACC_W       (ACC_W),
      .WIDTH_OUT   (WIDTH_OUT),
      .IS_SIGNED   (IS_SIGNED),
      .IS_FRACTION (IS_FRACTION)
   ) u_round (
      .acc_i  (acc_q),
      .data_o (rnd_data),
      .sat_o  (rnd_sat)
   );

   // Next state: accumulate, wrap the counter, register the rounded result in RND.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      data_d  = data_q;
      alive_d = alive_q;
      if (ena) begin
         alive_d = 1'b1;
         if (clear) begin
            state_d = ST_ACC;
            cnt_d   = '0;
            acc_d   = '0;
         end else begin
            if (accept) begin
               // The first sample of a batch overwrites the previous, already rounded, sum.
               acc_d = (cnt_q == '0) ? sample_ext : acc_q + sample_ext;
               cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
               ST_ACC: begin
                  if (accept && last_cnt) state_d = ST_RND;
               end
               ST_RND: begin
                  data_d  = rnd_data;
                  state_d = ST_OUT;
               end
               ST_OUT: begin
                  if (accept && last_cnt) begin
                     state_d = ST_RND;
                  end else if (m_hs) begin
                     state_d = ST_ACC;
                  end
               end
               default: state_d = ST_ACC;
            endcase
         end
      end
   end

   // State registers; asynchronous reset clears everything including the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
         cnt_q   <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         alive_q <= alive_d;
      end
   end

`ifdef SERIAL_ACC_SAT_FLAG_EN
   logic sat_q, sat_d;

   assign sat_d = (ena && !clear && (state_q == ST_RND)) ? rnd_sat : sat_q;

   // Saturation flag captured in the same cycle as the rounded data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= sat_d;
      end
   end

   assign m_sat = sat_q;
`else
   // The rounder drives a constant 0 flag in this build.
   assign m_sat = rnd_sat;
`endif

endmodule

// File: tb/tb_serial_accumulator_rounding.sv
// Self-checking bench for serial_accumulator_rounding. Three instances share the
// stimulus: A (signed fractional, 8-bit out), B (signed fractional, 7-bit out)
// and C (unsigned integer, 8-bit out). Honors SERIAL_ACC_SAT_FLAG_EN.
module tb_serial_accumulator_rounding;

   typedef struct {
      int data;
      int sat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n, ena, clear, s_valid, m_ready;
   logic [7:0] s_data;

   logic       s_ready_a, m_valid_a, m_sat_a;
   logic [7:0] m_data_a;
   logic       s_ready_b, m_valid_b, m_sat_b;
   logic [6:0] m_data_b;
   logic       s_ready_c, m_valid_c, m_sat_c;
   logic [7:0] m_data_c;

   int   checks   = 0;
   int   failures = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];
   int   batch[4];
   int   nb = 0;

   always #5 clk = ~clk;

   serial_accumulator_rounding #(.NUM_ACC(4), .WIDTH_IN(8), .WIDTH_OUT(8),
      .IS_SIGNED(1), .IS_FRACTION(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
      .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
      .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_sat(m_sat_a));

   serial_accumulator_rounding #(.NUM_ACC(4), .WIDTH_IN(8), .WIDTH_OUT(7),
      .IS_SIGNED(1), .IS_FRACTION(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
      .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
      .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_sat(m_sat_b));

   serial_accumulator_rounding #(.NUM_ACC(4), .WIDTH_IN(8), .WIDTH_OUT(8),
      .IS_SIGNED(0), .IS_FRACTION(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
      .s_valid(s_valid), .s_ready(s_ready_c), .s_data(s_data),
      .m_valid(m_valid_c), .m_ready(m_ready), .m_data(m_data_c), .m_sat(m_sat_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: exact integer sum, floor shift, ties to even, clamp.
   function automatic exp_t model(input int b[4], input int wout, input bit sgn, input bit frac);
      int   sum, sh, fl, rem, half, val, mx, mn;
      exp_t r;
      sum = 0;
      for (int i = 0; i < 4; i++) sum += (sgn && b[i] >= 128) ? b[i] - 256 : b[i];
      sh = 10 - wout;
      if (frac && sh > 0) begin
         fl   = sum >>> sh;
         rem  = sum - fl * (1 << sh);
         half = 1 << (sh - 1);
         if (rem > half || (rem == half && (fl % 2) != 0)) fl++;
         val = fl;
      end else if (frac && sh < 0) begin
         val = sum * (1 << (-sh));
      end else begin
         val = sum;
      end
      mx = sgn ? (1 << (wout - 1)) - 1 : (1 << wout) - 1;
      mn = sgn ? -(1 << (wout - 1)) : 0;
      r.sat = 0;
      if (val > mx) begin
         val = mx; r.sat = 1;
      end else if (val < mn) begin
         val = mn; r.sat = 1;
      end
      r.data = val & ((1 << wout) - 1);
`ifndef SERIAL_ACC_SAT_FLAG_EN
      r.sat = 0;
`endif
      return r;
   endfunction

   // Scoreboard: compare results on handshakes, predict results on accepted batches.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n || clear) begin
         nb = 0;
         q_a.delete(); q_b.delete(); q_c.delete();
      end else begin
         if (m_valid_a && m_ready) begin
            chk("out_a_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
               e = q_a.pop_front();
               chk("res_a_data", 32'(m_data_a), e.data);
               chk("res_a_sat", 32'(m_sat_a), e.sat);
            end
         end
         if (m_valid_b && m_ready) begin
            chk("out_b_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
               e = q_b.pop_front();
               chk("res_b_data", 32'(m_data_b), e.data);
               chk("res_b_sat", 32'(m_sat_b), e.sat);
            end
         end
         if (m_valid_c && m_ready) begin
            chk("out_c_expected", 32'(q_c.size() != 0), 1);
            if (q_c.size() != 0) begin
               e = q_c.pop_front();
               chk("res_c_data", 32'(m_data_c), e.data);
               chk("res_c_sat", 32'(m_sat_c), e.sat);
            end
         end
         if (s_valid && s_ready_a) begin
            batch[nb] = int'(s_data);
            nb++;
            if (nb == 4) begin
               q_a.push_back(model(batch, 8, 1'b1, 1'b1));
               q_b.push_back(model(batch, 7, 1'b1, 1'b1));
               q_c.push_back(model(batch, 8, 1'b0, 1'b0));
               nb = 0;
            end
         end
      end
   end

   // Present one sample and hold it until accepted; returns at posedge+1.
   task automatic send(input int v);
      s_data  = 8'(v);
      s_valid = 1'b1;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         if (s_ready_a) begin
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            return;
         end
      end
      checks++;
      failures++;
      $error("FAIL send_timeout observed=no_accept expected=accept value=%0d", v);
      s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ena = 1'b1; clear = 1'b0;
      s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", 32'(s_ready_a), 0);
      chk("rst_m_valid", 32'(m_valid_a), 0);
      chk("rst_m_data", 32'(m_data_a), 0);
      chk("rst_m_sat", 32'(m_sat_a), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("rdy_after_reset", 32'(s_ready_a), 1);
      idle(1);

      // Ties to even: 1.5 -> 2, 2.5 -> 2
      send(1); send(1); send(1); send(3);
      send(2); send(2); send(3); send(3);
      idle(8);

      // Most negative input and output latency
      send(-128); send(-128); send(-128);
      s_data = 8'h80; s_valid = 1'b1;
      @(negedge clk); chk("lat_last_ready", 32'(s_ready_a), 1);
      @(posedge clk); #1; s_valid = 1'b0;
      @(negedge clk); chk("lat_cycle1_m_valid", 32'(m_valid_a), 0);
      @(negedge clk); chk("lat_cycle2_m_valid", 32'(m_valid_a), 1);
      chk("lat_m_data", 32'(m_data_a), 32'h80);
      idle(4);

      // Rounding carry past maximum (instance B), plain max (A)
      send(127); send(127); send(127); send(127);
      idle(6);

      // Unsigned integer saturation (instance C)
      send(255); send(255); send(1); send(0);
      idle(6);

      // Backpressure: 8th sample stalls until the first result handshake
      m_ready = 1'b0;
      send(5); send(6); send(7); send(8);
      send(9); send(10); send(11);
      s_data = 8'd12; s_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_s_ready", 32'(s_ready_a), 0);
         chk("stall_m_valid", 32'(m_valid_a), 1);
         chk("stall_m_data", 32'(m_data_a), 6);
      end
      @(posedge clk); #1; m_ready = 1'b1;
      @(negedge clk);
      chk("hs_s_ready", 32'(s_ready_a), 1);
      chk("hs_m_valid", 32'(m_valid_a), 1);
      @(posedge clk); #1; s_valid = 1'b0;
      @(negedge clk); chk("hs_rnd_m_valid", 32'(m_valid_a), 0);
      @(negedge clk); chk("hs_second_m_valid", 32'(m_valid_a), 1);
      chk("hs_second_m_data", 32'(m_data_a), 10);
      idle(4);

      // Enable low freezes state and masks the handshake signals
      m_ready = 1'b0;
      send(20); send(20); send(20); send(20);
      idle(2);
      @(negedge clk); chk("pre_freeze_m_valid", 32'(m_valid_a), 1);
      @(posedge clk); #1; ena = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("freeze_m_valid", 32'(m_valid_a), 0);
         chk("freeze_s_ready", 32'(s_ready_a), 0);
      end
      @(posedge clk); #1; ena = 1'b1;
      @(negedge clk);
      chk("unfreeze_m_valid", 32'(m_valid_a), 1);
      chk("unfreeze_m_data", 32'(m_data_a), 20);
      @(posedge clk); #1; m_ready = 1'b1;
      idle(3);

      // Clear discards a partial batch
      send(100); send(100);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      send(4); send(4); send(4); send(4);
      idle(6);

      // Asynchronous reset while a result is held and a batch is partial
      m_ready = 1'b0;
      send(40); send(40); send(40); send(40);
      idle(3);
      send(1); send(1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_m_valid", 32'(m_valid_a), 0);
      chk("async_rst_m_data", 32'(m_data_a), 0);
      chk("async_rst_s_ready", 32'(s_ready_a), 0);
      chk("async_rst_m_sat", 32'(m_sat_a), 0);
      idle(2);
      rst_n = 1'b1; m_ready = 1'b1;
      idle(2);
      send(4); send(4); send(4); send(4);
      idle(8);

      chk("q_a_drained", 32'(q_a.size()), 0);
      chk("q_b_drained", 32'(q_b.size()), 0);
      chk("q_c_drained", 32'(q_c.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
